// File: rtl/tpm_rng_pkg.sv
// Shared constants and FSM state types for the rng byte pool.
package tpm_rng_pkg;

  localparam int unsigned RNG_WORD_W = 64;
  localparam int unsigned RNG_BYTES  = 8;

  typedef enum logic {
    R_IDLE,
    R_WAIT
  } refill_state_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_LOAD,
    B_SEND
  } byte_state_e;

endpackage

// File: rtl/rng_word_fifo.sv
// Show-ahead FIFO of 64-bit random words; the head word is visible whenever the FIFO is not empty.
module rng_word_fifo
  import tpm_rng_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [RNG_WORD_W-1:0]  i_push_data,
  input  logic                   i_pop,
  output logic [RNG_WORD_W-1:0]  o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [RNG_WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage carries no reset; flushing only clears pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rng_byte_pool.sv
// Keeps a pool of rng words topped up and serves byte requests from it, LSB byte first.
module rng_byte_pool
  import tpm_rng_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MAX_REQ_BYTES = 64,
  parameter int unsigned LEN_W         = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rng_start,
  input  logic [RNG_WORD_W-1:0]  rng_result,
  input  logic                   rng_valid,
  input  logic                   req_valid,
  input  logic [LEN_W-1:0]       req_len,
  output logic                   req_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   req_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned IDX_W = $clog2(RNG_BYTES);

  refill_state_e         r_rf_state;
  refill_state_e         w_rf_state_d;
  logic                  r_rng_start;
  logic                  w_rng_start_d;

  byte_state_e           r_b_state;
  byte_state_e           w_b_state_d;
  logic [LEN_W-1:0]      r_remaining;
  logic [LEN_W-1:0]      w_remaining_d;
  logic [IDX_W-1:0]      r_byte_idx;
  logic [IDX_W-1:0]      w_byte_idx_d;
  logic [RNG_WORD_W-1:0] r_word;
  logic [RNG_WORD_W-1:0] w_word_d;
  logic                  r_req_err;
  logic                  w_req_err_d;

  logic                  w_push;
  logic                  w_pop;
  logic [RNG_WORD_W-1:0] w_head;
  logic [$clog2(DEPTH):0] w_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_len_zero;
  logic                  w_len_big;

  rng_word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(rng_result),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Refill: one rng request in flight at a time, so a push can never find the pool full.
  always_comb begin
    w_rf_state_d  = r_rf_state;
    w_rng_start_d = 1'b0;
    w_push        = 1'b0;
    case (r_rf_state)
      R_IDLE: begin
        if (!w_full) begin
          w_rng_start_d = 1'b1;
          w_rf_state_d  = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rng_valid) begin
          w_push       = 1'b1;
          w_rf_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_state  <= R_IDLE;
      r_rng_start <= 1'b0;
    end else begin
      r_rf_state  <= w_rf_state_d;
      r_rng_start <= w_rng_start_d;
    end
  end

  assign w_len_zero = (req_len == '0);
  assign w_len_big  = (32'(req_len) > MAX_REQ_BYTES);

  // Byte server: the word register shifts right so the current byte is always bits [7:0].
  always_comb begin
    w_b_state_d   = r_b_state;
    w_remaining_d = r_remaining;
    w_byte_idx_d  = r_byte_idx;
    w_word_d      = r_word;
    w_req_err_d   = 1'b0;
    w_pop         = 1'b0;
    case (r_b_state)
      B_IDLE: begin
        if (req_valid) begin
          if (w_len_big) begin
            w_req_err_d = 1'b1;
          end else if (!w_len_zero) begin
            w_remaining_d = req_len;
            w_b_state_d   = B_LOAD;
          end
        end
      end
      B_LOAD: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_word_d     = w_head;
          w_byte_idx_d = '0;
          w_b_state_d  = B_SEND;
        end
      end
      B_SEND: begin
        if (out_ready) begin
          w_remaining_d = r_remaining - 1'b1;
          w_byte_idx_d  = r_byte_idx + 1'b1;
          w_word_d      = r_word >> 8;
          // Request completion wins over word exhaustion; leftover bytes are dropped.
          if (r_remaining == LEN_W'(1)) begin
            w_b_state_d = B_IDLE;
          end else if (r_byte_idx == IDX_W'(RNG_BYTES - 1)) begin
            w_b_state_d = B_LOAD;
          end
        end
      end
      default: w_b_state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_state   <= B_IDLE;
      r_remaining <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_req_err   <= 1'b0;
    end else begin
      r_b_state   <= w_b_state_d;
      r_remaining <= w_remaining_d;
      r_byte_idx  <= w_byte_idx_d;
      r_word      <= w_word_d;
      r_req_err   <= w_req_err_d;
    end
  end

  assign rng_start = r_rng_start;
  assign req_ready = (r_b_state == B_IDLE);
  assign out_valid = (r_b_state == B_SEND);
  assign out_data  = out_valid ? r_word[7:0] : 8'h00;
  assign out_last  = out_valid && (r_remaining == LEN_W'(1));
  assign req_err   = r_req_err;
  assign level     = w_level;

endmodule

// File: tb/tb_rng_byte_pool.sv
// Self-checking bench for rng_byte_pool: table of requests, random requests, and reset/stall corners.
module tb_rng_byte_pool;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAXB    = 64;
  localparam int unsigned LEN_W   = 7;
  localparam int          RSP_DLY = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rng_start;
  logic [63:0]      rng_result = '0;
  logic             rng_valid = 1'b0;
  logic             req_valid = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic             req_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             req_err;
  logic [2:0]       level;

  rng_byte_pool #(
    .DEPTH        (DEPTH),
    .MAX_REQ_BYTES(MAXB),
    .LEN_W        (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rng_start (rng_start),
    .rng_result(rng_result),
    .rng_valid (rng_valid),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .req_err   (req_err),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the n-th word the rng delivers, and the byte stream a request must see.
  function automatic logic [63:0] word_of(input int n);
    return 64'h0706050403020100 + 64'(n) * 64'h0808080808080808;
  endfunction

  int mdl_word = 0;  // index of the next pool word the block should hand out

  function automatic logic [7:0] exp_byte(input int k);
    logic [63:0] w;
    w = word_of(mdl_word + k / 8);
    return w[8*(k%8) +: 8];
  endfunction

  // rng model: answers each start RSP_DLY cycles later unless stalled; main flow
  // requests resets/injections by bumping counters so only this block drives rng_*.
  bit          stall = 1'b0;
  int          mrst_req = 0, mrst_seen = 0;
  int          inj_req = 0, inj_seen = 0;
  logic [63:0] inj_word = '0;
  int          rn = 0, cd = 0;
  bit          busy = 1'b0;

  always @(negedge clk) begin
    rng_valid = 1'b0;
    if (mrst_seen != mrst_req) begin
      mrst_seen = mrst_req;
      busy      = 1'b0;
      rn        = 0;
    end
    if (inj_seen != inj_req) begin
      inj_seen   = inj_req;
      rng_valid  = 1'b1;
      rng_result = inj_word;
    end else if (busy) begin
      if (cd == 1) begin
        rng_valid  = 1'b1;
        rng_result = word_of(rn);
        rn++;
        busy = 1'b0;
      end else begin
        cd--;
      end
    end
    if (rng_start === 1'b1 && !stall) begin
      busy = 1'b1;
      cd   = RSP_DLY;
    end
  end

  int start_cnt = 0;
  always @(posedge clk) if (rng_start === 1'b1) start_cnt++;

  task automatic wait_full(input string name);
    int c;
    c = 0;
    while (level !== 3'd4 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(level), 64'd4);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    mrst_req++;
    mdl_word = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input int len, input int mode, output int nb, output logic [7:0] fb,
                        output logic [7:0] lb, output int errs, output int nvalid);
    int         c;
    bit         prev_stall, done, big;
    logic [7:0] prev_d;
    logic       prev_l;
    big = (len > int'(MAXB));
    nb = 0; fb = '0; lb = '0; errs = 0; nvalid = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_len   = LEN_W'(len);
    c = 0;
    while (req_ready !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (len == 0 || big) begin
      check("req_ready_after_nop", 64'(req_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
        if (req_err === 1'b1) errs++;
        if (out_valid === 1'b1) nvalid++;
        @(negedge clk);
      end
    end else begin
      prev_stall = 1'b0; done = 1'b0; prev_d = '0; prev_l = 1'b0;
      c = 0;
      while (!done && c < 3000) begin
        case (mode)
          1:       out_ready = 1'b1;
          2:       out_ready = c[0];
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (req_err === 1'b1) errs++;
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(out_data), 64'(prev_d));
          check("hold_last", 64'(out_last), 64'(prev_l));
        end
        if (out_valid === 1'b1) begin
          if (out_ready) begin
            check("byte", 64'(out_data), 64'(exp_byte(nb)));
            check("last", 64'(out_last), 64'(nb == len - 1));
            if (nb == 0) fb = out_data;
            lb = out_data;
            nb++;
            if (out_last === 1'b1) done = 1'b1;
          end
          prev_stall = !out_ready;
          prev_d     = out_data;
          prev_l     = out_last;
        end else begin
          prev_stall = 1'b0;
        end
        @(negedge clk);
        c++;
      end
      check("req_done", 64'(done), 64'd1);
      out_ready = 1'b0;
      check("idle_after_last", 64'(out_valid), 64'd0);
      mdl_word += (len + 7) / 8;
    end
  endtask

  typedef struct {
    int         len;
    int         mode;
    int         n;
    logic [7:0] first;
    logic [7:0] last;
    int         err;
    int         starts;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int         nb, errs, nv, s0, len, mode, c;
    logic [7:0] fb, lb;

    tbl[0] = '{3,   1, 3, 8'h00, 8'h02, 0, 1};
    tbl[1] = '{5,   2, 5, 8'h08, 8'h0C, 0, 1};
    tbl[2] = '{0,   1, 0, 8'h00, 8'h00, 0, 0};
    tbl[3] = '{65,  1, 0, 8'h00, 8'h00, 1, 0};
    tbl[4] = '{8,   3, 8, 8'h10, 8'h17, 0, 1};
    tbl[5] = '{9,   1, 9, 8'h18, 8'h20, 0, 2};
    tbl[6] = '{127, 1, 0, 8'h00, 8'h00, 1, 0};
    tbl[7] = '{1,   2, 1, 8'h28, 8'h28, 0, 1};

    // Reset values and initial fill.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mrst_req++;
    mdl_word = 0;
    @(negedge clk);
    check("rst_rng_start", 64'(rng_start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_req_err", 64'(req_err), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    s0 = start_cnt;
    wait_full("fill_level");
    repeat (30) @(negedge clk);
    check("fill_starts", 64'(start_cnt - s0), 64'd4);
    check("fill_level_hold", 64'(level), 64'd4);
    check("fill_start_quiet", 64'(rng_start), 64'd0);

    // Table of requests against a full pool.
    for (int i = 0; i < 8; i++) begin
      s0 = start_cnt;
      do_req(tbl[i].len, tbl[i].mode, nb, fb, lb, errs, nv);
      if (i == 0) check("level_after_pop", 64'(level), 64'd3);
      wait_full("tbl_refill");
      check("tbl_nbytes", 64'(nb), 64'(tbl[i].n));
      check("tbl_err", 64'(errs), 64'(tbl[i].err));
      check("tbl_nvalid", 64'(nv), 64'd0);
      check("tbl_starts", 64'(start_cnt - s0), 64'(tbl[i].starts));
      if (tbl[i].n > 0) begin
        check("tbl_first", 64'(fb), 64'(tbl[i].first));
        check("tbl_last", 64'(lb), 64'(tbl[i].last));
      end
    end

    // Random requests, random back-pressure, random gaps.
    for (int i = 0; i < 14; i++) begin
      len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65, 127))
                                         : int'($urandom_range(0, 64));
      mode = int'($urandom_range(1, 3));
      do_req(len, mode, nb, fb, lb, errs, nv);
      check("rnd_nbytes", 64'(nb), (len > int'(MAXB)) ? 64'd0 : 64'(len));
      check("rnd_err", 64'(errs), (len > int'(MAXB)) ? 64'd1 : 64'd0);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    // Full 64-byte request with toggling ready.
    do_reset(2);
    wait_full("r64_fill");
    s0 = start_cnt;
    do_req(64, 2, nb, fb, lb, errs, nv);
    wait_full("r64_refill");
    check("r64_nbytes", 64'(nb), 64'd64);
    check("r64_first", 64'(fb), 64'h00);
    check("r64_last", 64'(lb), 64'h3F);
    check("r64_err", 64'(errs), 64'd0);
    check("r64_starts", 64'(start_cnt - s0), 64'd8);

    // Empty pool with rng stalled; a single late word feeds a 2-byte request.
    @(posedge clk);
    #1;
    stall = 1'b1;
    do_reset(2);
    repeat (10) @(negedge clk);
    check("stall_level", 64'(level), 64'd0);
    req_valid = 1'b1;
    req_len   = LEN_W'(2);
    check("stall_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) nv++;
      @(negedge clk);
    end
    check("stall_no_valid", 64'(nv), 64'd0);
    @(posedge clk);
    #1;
    inj_word = 64'h0000_0000_0000_AABB;
    inj_req++;
    @(negedge clk);
    @(negedge clk);
    check("late_valid_p1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("late_valid_p2", 64'(out_valid), 64'd1);
    check("late_byte0", 64'(out_data), 64'hBB);
    check("late_last0", 64'(out_last), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("late_byte1", 64'(out_data), 64'hAA);
    check("late_last1", 64'(out_last), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("late_done", 64'(out_valid), 64'd0);
    check("late_level", 64'(level), 64'd0);

    // Reset in the middle of a 16-byte request, with a stray rng_valid in R_IDLE.
    @(posedge clk);
    #1;
    stall = 1'b0;
    do_reset(1);
    wait_full("mid_fill");
    @(negedge clk);
    req_valid = 1'b1;
    req_len   = LEN_W'(16);
    @(negedge clk);
    req_valid = 1'b0;
    nb = 0;
    c  = 0;
    while (nb < 5 && c < 100) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        check("mid_byte", 64'(out_data), 64'(exp_byte(nb)));
        check("mid_last", 64'(out_last), 64'd0);
        nb++;
      end
      @(negedge clk);
      c++;
    end
    check("mid_nbytes", 64'(nb), 64'd5);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mrst_req++;
    mdl_word = 0;
    inj_word = 64'hDEAD_BEEF_CAFE_F00D;
    inj_req++;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_last", 64'(out_last), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_start", 64'(rng_start), 64'd0);
    @(negedge clk);
    check("mid_restart", 64'(rng_start), 64'd1);
    check("mid_stray_dropped", 64'(level), 64'd0);
    check("mid_idle_valid", 64'(out_valid), 64'd0);
    wait_full("mid_refill");
    do_req(8, 1, nb, fb, lb, errs, nv);
    check("mid_after_first", 64'(fb), 64'h00);
    check("mid_after_last", 64'(lb), 64'h07);
    check("mid_after_n", 64'(nb), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rng_byte_pool.md
Name: rng_byte_pool

Overview:
- Sits directly downstream of `rng`.
- Keeps a small pool of 64-bit random words topped up:
  - pulses the `rng` start input;
  - captures `result` on `valid`.
- Serves TPM2_GetRandom-style byte requests from that pool over a valid/ready byte stream.
- Used bytes are never reissued. Leftover bytes of a partially consumed word are discarded.

Parameters:
- DEPTH, 4, pool capacity in 64-bit words (power of 2, ≥2).
- MAX_REQ_BYTES, 64, largest legal request length.
- LEN_W, 7, width of the request length field.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rng_start  out  1  one-cycle request pulse to `rng`
- rng_result  in  64  word from `rng`
- rng_valid  in  1  one-cycle strobe qualifying rng_result
- req_valid  in  1  byte request present
- req_len  in  LEN_W  requested byte count
- req_ready  out  1  block accepts a request
- out_data  out  8  random byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte
- out_last  out  1  final byte of current request
- req_err  out  1  one-cycle pulse: request rejected
- level  out  $clog2(DEPTH)+1  words currently in pool

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - rng_start=0, out_valid=0, out_last=0, req_err=0, level=0, out_data=0.
  - Both FSMs reset to IDLE.
  - Pool is flushed.
- Refill FSM, states R_IDLE and R_WAIT:
  - R_IDLE→R_WAIT when level<DEPTH. rng_start is high for exactly that one cycle.
  - R_WAIT: on rng_valid, push rng_result, then return to R_IDLE.
  - At most one outstanding rng request.
  - rng_valid outside R_WAIT is ignored.
- Byte FSM, states B_IDLE, B_LOAD, B_SEND:
  - req_ready = (state==B_IDLE).
  - Handshake: req_valid & req_ready.
  - B_IDLE, len==0: accept; no output; stay in B_IDLE.
  - B_IDLE, len>MAX_REQ_BYTES: accept; req_err pulses the next cycle; no output.
  - B_IDLE, otherwise: remaining←len; go to B_LOAD.
  - B_LOAD: wait for level≠0. Then pop the head word into a 64-bit shift register, set byte_idx←0, go to B_SEND. out_valid rises the cycle after the pop.
  - B_SEND: out_data = word[8*byte_idx +: 8], LSB byte first.
  - out_last = (remaining==1).
  - On out_valid & out_ready: remaining−−, byte_idx++.
    - If remaining was 1 → B_IDLE. Unused bytes of the word are dropped.
    - Else if byte_idx was 7 → B_LOAD.
  - out_data and out_last hold stable while out_valid & !out_ready.
- Pool:
  - Push and pop in the same cycle leave level unchanged.
  - No push when full (guaranteed by the refill condition).
  - Pop only when level≠0.
- Reset mid-operation:
  - Current request is aborted; no out_last is issued.
  - In-flight rng word is dropped.
  - Refill restarts from R_IDLE the cycle after rst falls.
- rng and this block share rst.

Decomposition:
- Package tpm_rng_pkg:
  - RNG_WORD_W=64, RNG_BYTES=8;
  - refill_state_e {R_IDLE, R_WAIT};
  - byte_state_e {B_IDLE, B_LOAD, B_SEND}.
- Sub-module rng_word_fifo:
  - synchronous show-ahead FIFO, DEPTH×64;
  - push/pop/level outputs;
  - flushed on rst.
- Top level holds both FSMs and the byte shift register.

Test Plan:
1. Reset; rng model answers rng_valid 5 cycles after each start with words 0x0706050403020100 + n·0x0808080808080808 → exactly 4 rng_start pulses, level=4, then rng_start stays 0.
2. Pool full, req_len=3 → out_data 0x00, 0x01, 0x02 with out_last on 0x02. Level goes 4→3, then one rng_start. The next request starts at 0x08, not 0x03.
3. req_len=64 with out_ready toggling every cycle → exactly 64 bytes, 0x00..0x3F in order, with out_last only on 0x3F. Then 8 pops, and the pool refills to 4.
4. req_len=0 → no out_valid, req_ready high the next cycle. req_len=65 → req_err high exactly 1 cycle, no out_valid.
5. Empty pool with rng model stalled, req_len=2 → out_valid stays 0. When rng_valid arrives with word 0xAABB, the bytes are 0xBB then 0xAA, with out_valid starting 2 cycles after rng_valid (push then pop).
6. rst for 1 cycle after 5 of 16 bytes, with a late rng_valid arriving in R_IDLE → out_valid=0 and level=0 after reset, late word not stored, refill resumes with rng_start the cycle after rst falls.
